// File: rtl/packet_pkg.sv
// Shared definitions for the packet merger: default sizes, match-criteria tag field
// and the round-robin search helper.
package packet_pkg;

    localparam int PATH_COUNT_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int TAG_MSB        = 31;
    localparam int TAG_LSB        = 28;

    typedef logic [31:0] match_criteria_t;

    // First set bit of req searching upward from ptr+1, wrapping; unused request
    // bits must be zero so the 16-wide wrap matches a PATH_COUNT-wide wrap.
    function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] ptr);
        logic [3:0] idx;
        logic [3:0] grant;
        logic       found;
        grant = ptr;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = ptr + 4'(k);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/packet_merger_fifo.sv
// Single-clock synchronous FIFO holding the beats of one merger input path.
module packet_merger_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rptr;
    logic [AW-1:0]         wptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/packet_merger.sv
// Merges PATH_COUNT per-path beat streams onto one registered valid/ready stream
// with round-robin arbitration. Define PACKET_MERGER_TAG_EN to stamp source tags.
module packet_merger
    import packet_pkg::*;
#(
    parameter int PATH_COUNT = PATH_COUNT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                                  iClk,
    input  logic                                  iRst,
    input  logic [PATH_COUNT-1:0][DATA_WIDTH-1:0] iData,
    input  logic [PATH_COUNT-1:0]                 iDataVld,
    output logic [PATH_COUNT-1:0]                 oDataRdy,
    output logic                                  oPktValid,
    output logic [DATA_WIDTH-1:0]                 oPktData,
    output logic [$clog2(PATH_COUNT)-1:0]         oPktPath,
    input  logic                                  iPktReady,
    input  match_criteria_t [PATH_COUNT-1:0]      iRegMatchCriteria
);

    localparam int PW = $clog2(PATH_COUNT);

    logic                  run;
    logic [PATH_COUNT-1:0] push;
    logic [PATH_COUNT-1:0] pop;
    logic [PATH_COUNT-1:0] full;
    logic [PATH_COUNT-1:0] empty;
    logic [DATA_WIDTH-1:0] rdata [PATH_COUNT];
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         grant;
    logic [15:0]           req;
    logic [3:0]            grant_raw;
    logic                  load_en;
    logic                  any_req;
    logic                  do_load;
    logic [DATA_WIDTH-1:0] load_data;

    // run keeps every ready low while reset is held and for the reset edge itself.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign oDataRdy = {PATH_COUNT{run}} & ~full;
    assign push     = iDataVld & oDataRdy;

    for (genvar i = 0; i < PATH_COUNT; i++) begin : g_path
        packet_merger_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (iClk),
            .rst_n(iRst),
            .push (push[i]),
            .pop  (pop[i]),
            .wdata(iData[i]),
            .rdata(rdata[i]),
            .full (full[i]),
            .empty(empty[i])
        );
    end

    assign load_en = !oPktValid || iPktReady;
    assign any_req = |(~empty);
    assign do_load = load_en && any_req;

    always_comb begin
        req                 = '0;
        req[PATH_COUNT-1:0] = ~empty;
        grant_raw           = rr_next(req, 4'(rr_ptr));
    end

    assign grant = grant_raw[PW-1:0];

    always_comb begin
        pop = '0;
        if (do_load) begin
            pop[grant] = 1'b1;
        end
    end

`ifdef PACKET_MERGER_TAG_EN
    always_comb begin
        load_data = rdata[grant];
        load_data[DATA_WIDTH-1 -: TAG_WIDTH] = iRegMatchCriteria[grant][TAG_MSB -: TAG_WIDTH];
    end
`else
    logic unused_criteria;
    assign unused_criteria = ^iRegMatchCriteria;
    assign load_data       = rdata[grant];
`endif

    // Output register: loads on grant, clears valid when nothing is pending, holds on stall.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            oPktValid <= 1'b0;
            oPktData  <= '0;
            oPktPath  <= '0;
            rr_ptr    <= PW'(PATH_COUNT - 1);
        end else if (load_en) begin
            oPktValid <= any_req;
            if (any_req) begin
                oPktData <= load_data;
                oPktPath <= grant;
                rr_ptr   <= grant;
            end
        end
    end

endmodule

// File: tb/tb_packet_merger.sv
// Scoreboard bench for packet_merger: queue-based reference model, directed
// scenarios plus a randomized traffic phase.
`timescale 1ns/1ps
module tb_packet_merger;
    import packet_pkg::*;

    localparam int PC = 4;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int TW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PC-1:0][DW-1:0] data;
    logic [PC-1:0]         data_vld;
    logic [PC-1:0]         data_rdy;
    logic                  pkt_valid;
    logic [DW-1:0]         pkt_data;
    logic [1:0]            pkt_path;
    logic                  pkt_ready;
    match_criteria_t [PC-1:0] crit;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    packet_merger #(
        .PATH_COUNT(PC),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD),
        .TAG_WIDTH (TW)
    ) dut (
        .iClk             (clk),
        .iRst             (rst),
        .iData            (data),
        .iDataVld         (data_vld),
        .oDataRdy         (data_rdy),
        .oPktValid        (pkt_valid),
        .oPktData         (pkt_data),
        .oPktPath         (pkt_path),
        .iPktReady        (pkt_ready),
        .iRegMatchCriteria(crit)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: per-path queues, one output slot, round-robin pointer.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    p;
    } beat_t;

    logic [DW-1:0] mq [PC][$];
    beat_t         exp_q[$];
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    m_path;
    int            m_ptr = PC - 1;
    logic          m_run = 1'b0;
    logic [PC-1:0] m_acc = '0;

    function automatic logic [DW-1:0] stamp(logic [DW-1:0] d, int p);
        logic [DW-1:0] r;
        r = d;
`ifdef PACKET_MERGER_TAG_EN
        r[DW-1 -: TW] = crit[p][31 -: TW];
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst) begin
            for (int i = 0; i < PC; i++) mq[i].delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_path  = '0;
            m_ptr   = PC - 1;
            m_run   = 1'b0;
            m_acc   = '0;
        end else begin
            for (int i = 0; i < PC; i++)
                m_acc[i] = data_vld[i] && m_run && (mq[i].size() < FD);
            if (!m_valid || pkt_ready) begin
                g = -1;
                for (int k = 1; k <= PC; k++)
                    if (g < 0 && mq[(m_ptr + k) % PC].size() > 0) g = (m_ptr + k) % PC;
                if (g >= 0) begin
                    m_data  = stamp(mq[g].pop_front(), g);
                    m_path  = 2'(g);
                    m_ptr   = g;
                    m_valid = 1'b1;
                    exp_q.push_back('{d: m_data, p: m_path});
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < PC; i++)
                if (m_acc[i]) mq[i].push_back(data[i]);
            m_run = 1'b1;
        end
    end

    // Monitor: compares each newly presented beat with the scoreboard head.
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_path;

    always @(negedge clk) begin
        logic [PC-1:0] er;
        beat_t         e;
        for (int i = 0; i < PC; i++) er[i] = m_run && (mq[i].size() < FD);
        chk("data_rdy", data_rdy, er);
        chk("pkt_valid", pkt_valid, m_valid);
        if (pkt_valid && prev_valid && !prev_ready) begin
            chk("stall_data", pkt_data, prev_data);
            chk("stall_path", pkt_path, prev_path);
        end else if (pkt_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", pkt_data, e.d);
                chk("beat_path", pkt_path, e.p);
            end
        end
        prev_valid = pkt_valid;
        prev_ready = pkt_ready;
        prev_data  = pkt_data;
        prev_path  = pkt_path;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_crit_default();
        for (int i = 0; i < PC; i++) crit[i] = 32'(i) << 28;
    endtask

    initial begin
        int n_acc;
        rst       = 1'b0;
        data      = '0;
        data_vld  = '0;
        pkt_ready = 1'b1;
        set_crit_default();

        // Reset and idle
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_data", pkt_data, 0);
        chk("rst_path", pkt_path, 0);
        chk("rst_rdy", data_rdy, 0);
        cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("rdy_after_release", data_rdy, 4'hF);

        // Round robin, two rounds
        for (int r = 0; r < 2; r++) begin
            cyc();
            data     = {8'h35, 8'h27, 8'h15, 8'h05} + {4{8'(r)}};
            data_vld = '1;
            cyc();
            data_vld = '0;
            cyc();
            for (int k = 0; k < PC; k++) begin
                @(negedge clk);
                chk("rr_valid", pkt_valid, 1);
                chk("rr_path", pkt_path, k);
                cyc();
            end
            @(negedge clk);
            chk("rr_idle", pkt_valid, 0);
        end

        // Single beat latency on path 2
        cyc();
        data[2]  = 8'h25;
        data_vld = 4'b0100;
        cyc();
        data_vld = '0;
        @(negedge clk);
        chk("lat_not_early", pkt_valid, 0);
        cyc();
        @(negedge clk);
        chk("lat_valid", pkt_valid, 1);
        chk("lat_data", pkt_data, 8'h25);
        chk("lat_path", pkt_path, 2);
        cyc();
        @(negedge clk);
        chk("lat_after", pkt_valid, 0);

        // Tag stamping on path 3
        cyc();
        data[3]  = 8'hA5;
        data_vld = 4'b1000;
        cyc();
        data_vld = '0;
        cyc();
        @(negedge clk);
`ifdef PACKET_MERGER_TAG_EN
        chk("tag_data", pkt_data, 8'h35);
`else
        chk("tag_data", pkt_data, 8'hA5);
`endif
        chk("tag_path", pkt_path, 3);

        // Backpressure on path 1 until its FIFO fills
        cyc();
        cyc();
        pkt_ready = 1'b0;
        n_acc     = 0;
        for (int b = 0; b < 6; b++) begin
            data[1]  = 8'h10 + 8'(b);
            data_vld = 4'b0010;
            for (int w = 0; w < 8; w++) begin
                cyc();
                if (m_acc[1]) break;
            end
            if (m_acc[1]) n_acc++;
        end
        chk("bp_accepted", n_acc, 5);
        @(negedge clk);
        chk("bp_full_rdy", data_rdy[1], 0);
        chk("bp_head", pkt_data, 8'h10);
        data_vld = '0;
        repeat (3) cyc();
        pkt_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_order", pkt_data, 8'h10 + 32'(k));
            cyc();
        end
        @(negedge clk);
        chk("bp_drained", pkt_valid, 0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            cyc();
            for (int i = 0; i < PC; i++) begin
                data[i]     = 8'($urandom);
                data_vld[i] = ($urandom_range(0, 3) != 0);
                crit[i]     = $urandom;
            end
            pkt_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        data_vld  = '0;
        pkt_ready = 1'b1;
        set_crit_default();
        repeat (30) cyc();

        // Reset while beats are buffered and presented
        pkt_ready = 1'b0;
        data      = {8'h33, 8'h22, 8'h11, 8'h00};
        data_vld  = '1;
        cyc();
        data_vld = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("mid_valid_before", pkt_valid, 1);
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("mid_valid_rst", pkt_valid, 0);
        cyc();
        rst       = 1'b1;
        pkt_ready = 1'b1;
        cyc();
        data[0]  = 8'h0A;
        data[3]  = 8'h3B;
        data_vld = 4'b1001;
        cyc();
        data_vld = '0;
        cyc();
        @(negedge clk);
        chk("mid_first_path", pkt_path, 0);
        chk("mid_first_data", pkt_data, 8'h0A);
        cyc();
        @(negedge clk);
        chk("mid_second_path", pkt_path, 3);
        chk("mid_second_data", pkt_data, 8'h3B);
        repeat (5) cyc();
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/packet_merger.md
Name: packet_merger

Overview:
- Inverse of packet_router: collects per-path beat streams from PATH_COUNT sources and merges them onto one packet stream.
- Uses a per-path FIFO, a round-robin arbiter and a registered valid/ready output.
- The output feeds a packet_router ingress (iPktValid/iPktData) or an egress link.
- Optional tag insertion stamps each beat with its source path's match-criteria nibble, so a downstream router reproduces the original split.

Parameters:
- PATH_COUNT, 4, number of input paths (2..16).
- DATA_WIDTH, 8, beat width in bits (>= TAG_WIDTH).
- FIFO_DEPTH, 4, entries per path FIFO (power of 2, >= 2).
- TAG_WIDTH, 4, width of tag field at data MSBs; used only with tag insertion.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset; synchronous, active-low (0 = reset, sampled on iClk rising edge).
- iData  in  PATH_COUNT x DATA_WIDTH  per-path beat data.
- iDataVld  in  PATH_COUNT  per-path beat valid.
- oDataRdy  out  PATH_COUNT  per-path ready; beat i accepted on an edge where iDataVld[i] && oDataRdy[i].
- oPktValid  out  1  merged beat valid.
- oPktData  out  DATA_WIDTH  merged beat data.
- oPktPath  out  $clog2(PATH_COUNT)  source path index of the current oPktData.
- iPktReady  in  1  downstream ready; beat transfers on an edge where oPktValid && iPktReady.
- iRegMatchCriteria  in  PATH_COUNT x 32  per-path tag config; bits [31:28] hold the tag for path i.

Behaviour:
- Reset (iRst == 0 at an edge):
  - All FIFOs emptied.
  - oDataRdy = all 1s on the cycle after reset release; held all 0s during reset.
  - oPktValid = 0, oPktData = 0, oPktPath = 0.
  - RR pointer = PATH_COUNT-1, so path 0 has first priority.
  - Reset mid-operation discards all buffered and output-register beats with no partial output.
- FIFO per path:
  - oDataRdy[i] = !full[i], registered-state based.
  - A push on a full FIFO is never accepted, even if a pop occurs on the same edge.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Count is $clog2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished.
- Output register load condition: load_en = !oPktValid || iPktReady.
- Arbiter:
  - When load_en, grant = first non-empty FIFO searching from RR pointer+1 upward, modulo PATH_COUNT.
  - Grant pops that FIFO and loads oPktData/oPktPath; oPktValid = 1.
  - RR pointer updates to the granted index only on an actual grant.
  - If load_en and no FIFO is non-empty: oPktValid = 0; data/path hold their last values.
- Stall: while oPktValid && !iPktReady, oPktData/oPktValid/oPktPath are held stable; no pops occur.
- Latency: a beat pushed at edge t into an empty system appears on the outputs after edge t+1 (2-edge latency).
- Throughput: 1 beat/cycle when iPktReady is held 1.
- Ordering: per-path order is preserved; there is no inter-path ordering guarantee beyond round-robin.
- Fairness: with all paths continuously non-empty, grants follow 0,1,2,3,0,... No path waits more than PATH_COUNT-1 grants.

Optional Feature:
- Macro: PACKET_MERGER_TAG_EN.
- Defined: on load, oPktData[DATA_WIDTH-1 -: TAG_WIDTH] = iRegMatchCriteria[grant][31:28]; the lower bits pass unchanged. iRegMatchCriteria is sampled at load time.
- Undefined: data passes unmodified and iRegMatchCriteria is unused, but the port is still present.

Decomposition:
- packet_pkg holds:
  - PATH_COUNT_DEF and DATA_WIDTH_DEF.
  - TAG_MSB = 31 and TAG_LSB = 28 (match-criteria tag field).
  - typedef match_criteria_t (logic [31:0]).
  - function rr_next(req, ptr) returning the grant index.
- Sub-module packet_merger_fifo: single-clock synchronous FIFO with params DATA_WIDTH and FIFO_DEPTH, and ports push, pop, full, empty, wdata, rdata. It is instantiated PATH_COUNT times via generate.

Test Plan:
- Reset/idle: iRst=0 for 2 cycles, then 1, all iDataVld=0 -> oPktValid=0, oPktData=0, oDataRdy=4'b1111 after release.
- Single path: iData[2]=8'h25 for one beat, iPktReady=1 -> oPktValid=1, oPktData=8'h25, oPktPath=2 exactly 2 edges after acceptance, then oPktValid=0.
- Round-robin: all 4 paths hold a beat each (8'h05, 8'h15, 8'h27, 8'h35) pushed on the same edge -> output order paths 0,1,2,3 on 4 consecutive cycles; a second round starting with the pointer at 3 resumes at path 0.
- Backpressure/full: iPktReady=0, path 1 drives 6 beats 8'h10..8'h15 -> 4 accepted (FIFO_DEPTH), 1 held in the output register, oDataRdy[1]=0 at full. On iPktReady=1 the beats emerge in order 8'h10..8'h14; the output stays stable while stalled.
- Tag (PACKET_MERGER_TAG_EN, criteria[i][31:28]=i): path 3 sends 8'hA5 -> oPktData=8'h35. Without the macro, oPktData=8'hA5.
- Reset mid-stream: assert iRst=0 while 3 beats are buffered and oPktValid=1 -> next cycle oPktValid=0, all FIFOs empty. After release, no stale beats appear and path 0 has first priority.
